uart_rx_fifo_controller: RTL and testbench

//  Parametrised UART receiver: runtime baud divisor, 5-9 data bits, optional even/odd parity,
//  1 or 2 stop bits, 3-sample majority vote at mid-bit, and a first-word-fall-through receive

---
 rtl/uart_rx_fifo_controller.sv | 159 +++++++++++++++
 tb/tb_uart_rx_fifo_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_controller.sv
// UART receiver: 3-sample majority bit decision, optional parity, 1/2 stop bits,
// feeding a first-word-fall-through FIFO whose words carry parity/frame error flags.
module uart_rx_fifo_controller #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                        Clock_50,
    input  logic                        Resetn,
    input  logic                        Enable,
    input  logic [DIV_WIDTH-1:0]        Baud_div,
    input  logic [1:0]                  Parity_mode,
    input  logic                        Two_stop,
    input  logic                        Unload_data,
    input  logic                        Clear_status,
    output logic [DATA_BITS-1:0]        RX_data,
    output logic                        Parity_error,
    output logic                        Frame_error,
    output logic                        Empty,
    output logic                        Full,
    output logic [$clog2(FIFO_DEPTH):0] Fill_level,
    output logic                        Overrun,
    input  logic                        UART_RX_I
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int WW = DATA_BITS + 2;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;
    state_t r_state, w_next;

    logic                 r_sync1, r_rx_s, r_armed;
    logic [DIV_WIDTH-1:0] r_count, r_div, w_mid;
    logic [1:0]           r_pmode;
    logic                 r_two, r_s0, r_s1, r_perr, r_ferr, r_overrun;
    logic [DATA_BITS-1:0] r_shift;
    logic [BW-1:0]        r_bitcnt;
    logic                 w_dec, w_maj, w_par_en, w_last_bit, w_start, w_push;

    logic [WW-1:0]        r_mem [FIFO_DEPTH];
    logic [AW:0]          r_wr, r_rd, w_level;
    logic [WW-1:0]        w_head, w_word;
    logic                 w_pop, w_wr_en;

    // START samples around the half-bit point; later bits one full period after each decision
    assign w_mid      = (r_state == S_START) ? (r_div >> 1) : (r_div - DIV_WIDTH'(2));
    assign w_dec      = (r_state != S_IDLE) && (r_count == w_mid + DIV_WIDTH'(1));
    assign w_maj      = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
    assign w_par_en   = r_pmode[0] ^ r_pmode[1];
    assign w_last_bit = (r_bitcnt == BW'(DATA_BITS - 1));

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_state <= S_IDLE;
        end else begin
            r_sync1 <= UART_RX_I;
            r_rx_s  <= r_sync1;
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE) begin
            if (w_start) w_next = S_START;
        end else if (!Enable) begin
            w_next = S_IDLE;
        end else if (w_dec) begin
            case (r_state)
                S_START:  w_next = w_maj ? S_IDLE : S_DATA;
                S_DATA:   if (w_last_bit) w_next = w_par_en ? S_PARITY : S_STOP1;
                S_PARITY: w_next = S_STOP1;
                S_STOP1:  w_next = r_two ? S_STOP2 : S_IDLE;
                S_STOP2:  w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_start = (r_state == S_IDLE) && Enable && r_armed && !r_rx_s;
        w_push  = Enable && w_dec && ((r_state == S_STOP1 && !r_two) || r_state == S_STOP2);
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_armed  <= 1'b0;
            r_count  <= '0;
            r_div    <= '0;
            r_pmode  <= '0;
            r_two    <= 1'b0;
            r_s0     <= 1'b1;
            r_s1     <= 1'b1;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
            r_shift  <= '0;
            r_bitcnt <= '0;
        end else begin
            // a frame ending on a low line (break) must see the line high before re-arming
            if (r_state == S_IDLE && r_rx_s) r_armed <= 1'b1;
            else if (w_push && !r_rx_s)      r_armed <= 1'b0;
            r_count <= (r_state == S_IDLE || w_dec) ? '0 : r_count + DIV_WIDTH'(1);
            if (r_count == w_mid - DIV_WIDTH'(1)) r_s0 <= r_rx_s;
            if (r_count == w_mid)                 r_s1 <= r_rx_s;
            if (w_start) begin
                r_div    <= Baud_div;
                r_pmode  <= Parity_mode;
                r_two    <= Two_stop;
                r_bitcnt <= '0;
                r_perr   <= 1'b0;
                r_ferr   <= 1'b0;
            end else if (w_dec) begin
                case (r_state)
                    S_DATA: begin
                        r_shift  <= {w_maj, r_shift[DATA_BITS-1:1]};
                        r_bitcnt <= r_bitcnt + BW'(1);
                    end
                    S_PARITY:         r_perr <= (^r_shift) ^ w_maj ^ r_pmode[1];
                    S_STOP1, S_STOP2: r_ferr <= r_ferr | ~w_maj;
                    default: ;
                endcase
            end
        end
    end

    assign w_word  = {r_ferr | ~w_maj, r_perr, r_shift};
    assign w_level = r_wr - r_rd;
    assign Empty   = (w_level == '0);
    assign Full    = (w_level == (AW+1)'(FIFO_DEPTH));
    assign w_pop   = Unload_data && !Empty;
    assign w_wr_en = w_push && (!Full || w_pop);

    // when full, a simultaneous pop frees exactly the slot being written
    always_ff @(posedge Clock_50) begin
        if (w_wr_en) r_mem[r_wr[AW-1:0]] <= w_word;
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_wr      <= '0;
            r_rd      <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr_en) r_wr <= r_wr + (AW+1)'(1);
            if (w_pop)   r_rd <= r_rd + (AW+1)'(1);
            if (w_push && !w_wr_en) r_overrun <= 1'b1;
            else if (Clear_status)  r_overrun <= 1'b0;
        end
    end

    assign w_head       = r_mem[r_rd[AW-1:0]];
    assign RX_data      = Empty ? '0 : w_head[DATA_BITS-1:0];
    assign Parity_error = !Empty && w_head[DATA_BITS];
    assign Frame_error  = !Empty && w_head[DATA_BITS+1];
    assign Fill_level   = w_level;
    assign Overrun      = r_overrun;
endmodule

// File: tb/tb_uart_rx_fifo_controller.sv
// Bench for uart_rx_fifo_controller: frame vector table, directed corner sequences and
// randomized frames scored against a queue of expected FIFO words.
module tb_uart_rx_fifo_controller;
    logic        clk = 1'b0, rstn = 1'b0, en = 1'b0;
    logic [15:0] div = 16'd8;
    logic [1:0]  pmode = 2'b00;
    logic        two = 1'b0, unload = 1'b0, clr = 1'b0, rx = 1'b1;
    logic [7:0]  rdata;
    logic        pe, fe, empty, full, ovr;
    logic [4:0]  level;
    logic        rx5 = 1'b1, unload5 = 1'b0;
    logic [4:0]  rdata5;
    logic        pe5, fe5, empty5, full5, ovr5;
    logic [4:0]  level5;

    int n_tests = 0, n_fail = 0;

    typedef struct {
        logic [7:0] d;
        logic [1:0] pm;
        logic       pb, s1, s2, tw;
        logic       epe, efe;
    } vec_t;
    vec_t tbl[7];

    logic [9:0] q[$];
    logic [7:0] rd8;
    logic [1:0] rpm;
    logic       rtw, rflip, rbad1, rbad2, rgood;
    int         dvs[4] = '{8, 9, 12, 16};

    always #5 clk = ~clk;

    uart_rx_fifo_controller #(.DATA_BITS(8), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
        .Clock_50(clk), .Resetn(rstn), .Enable(en), .Baud_div(div), .Parity_mode(pmode),
        .Two_stop(two), .Unload_data(unload), .Clear_status(clr), .RX_data(rdata),
        .Parity_error(pe), .Frame_error(fe), .Empty(empty), .Full(full), .Fill_level(level),
        .Overrun(ovr), .UART_RX_I(rx));

    uart_rx_fifo_controller #(.DATA_BITS(5), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut5 (
        .Clock_50(clk), .Resetn(rstn), .Enable(en), .Baud_div(div), .Parity_mode(pmode),
        .Two_stop(two), .Unload_data(unload5), .Clear_status(clr), .RX_data(rdata5),
        .Parity_error(pe5), .Frame_error(fe5), .Empty(empty5), .Full(full5), .Fill_level(level5),
        .Overrun(ovr5), .UART_RX_I(rx5));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_pe"},    pe, 0);
        check({tag, "_fe"},    fe, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"},  full, 0);
        check({tag, "_level"}, level, 0);
        check({tag, "_ovr"},   ovr, 0);
    endtask

    task automatic idle(input int n);
        rx = 1'b1; rx5 = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input bit to5, input bit spike);
        if (to5) rx5 = b; else rx = b;
        if (spike) begin
            repeat (4) @(negedge clk);
            rx = ~b; @(negedge clk); rx = b;
            repeat (div - 5) @(negedge clk);
        end else begin
            repeat (div) @(negedge clk);
        end
    endtask

    // pbit is only sent for even/odd modes; sp = index of data bit carrying a one-clock spike
    task automatic send_frame(input logic [8:0] d, input int nb, input logic [1:0] pm,
                              input logic pbit, input logic st1, input logic st2,
                              input logic tw, input bit to5, input int sp);
        pmode = pm; two = tw;
        send_bit(1'b0, to5, 0);
        for (int i = 0; i < nb; i++) send_bit(d[i], to5, i == sp);
        if (pm == 2'b01 || pm == 2'b10) send_bit(pbit, to5, 0);
        send_bit(st1, to5, 0);
        if (tw) send_bit(st2, to5, 0);
    endtask

    task automatic send8(input logic [7:0] d);
        send_frame({1'b0, d}, 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 0, -1);
        idle(6);
    endtask

    task automatic pop();
        unload = 1'b1; @(negedge clk); unload = 1'b0;
    endtask

    task automatic drain();
        logic [9:0] e;
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 64) begin
            e = q.pop_front();
            check("rnd_data", rdata, e[7:0]);
            check("rnd_pe", pe, e[8]);
            check("rnd_fe", fe, e[9]);
            pop();
            guard++;
        end
        check("rnd_empty", empty, 1);
    endtask

    initial begin
        #900000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        tbl[0] = '{8'hA5, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h03, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{8'h03, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{8'h3C, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{8'hFF, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{8'h81, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{8'h00, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        check_reset("reset");
        rstn = 1'b1; en = 1'b1;
        idle(10);

        for (int i = 0; i < 7; i++) begin
            send_frame({1'b0, tbl[i].d}, 8, tbl[i].pm, tbl[i].pb, tbl[i].s1, tbl[i].s2,
                       tbl[i].tw, 0, -1);
            idle(6);
            check($sformatf("vec%0d_data", i), rdata, tbl[i].d);
            check($sformatf("vec%0d_pe", i), pe, tbl[i].epe);
            check($sformatf("vec%0d_fe", i), fe, tbl[i].efe);
            check($sformatf("vec%0d_empty", i), empty, 0);
            check($sformatf("vec%0d_level", i), level, 1);
            pop();
            check($sformatf("vec%0d_popempty", i), empty, 1);
        end

        // bad second stop bit, then line held low (break) for 20 bit times
        send_frame(9'h05A, 8, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 0, -1);
        rx = 1'b0;
        repeat (20 * 8) @(negedge clk);
        check("brk_level", level, 1);
        check("brk_data", rdata, 8'h5A);
        check("brk_fe", fe, 1);
        check("brk_pe", pe, 0);
        idle(6);
        send_frame(9'h0C3, 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 0, -1);
        idle(6);
        check("brk_level2", level, 2);
        pop();
        check("brk_next", rdata, 8'hC3);
        check("brk_next_fe", fe, 0);
        pop();

        // overrun and ordering
        for (int i = 0; i < 16; i++) send8(8'(i));
        check("fill_full", full, 1);
        check("fill_level", level, 16);
        check("fill_ovr", ovr, 0);
        send8(8'h10);
        check("ovr_set", ovr, 1);
        check("ovr_full", full, 1);
        check("ovr_head", rdata, 8'h00);
        check("ovr_level", level, 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("order%0d", i), rdata, 8'(i));
            pop();
        end
        check("order_empty", empty, 1);
        check("ovr_sticky", ovr, 1);
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        check("ovr_clear", ovr, 0);

        // pop lands on the same clock as the final stop decision of a push while full
        for (int i = 0; i < 16; i++) send8(8'h20 + 8'(i));
        check("pp_full", full, 1);
        fork
            send_frame(9'h077, 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 0, -1);
            begin
                repeat (80) @(negedge clk);
                unload = 1'b1; @(negedge clk); unload = 1'b0;
            end
        join
        idle(6);
        check("pp_ovr", ovr, 0);
        check("pp_level", level, 16);
        check("pp_head", rdata, 8'h21);
        for (int i = 1; i < 16; i++) pop();
        check("pp_tail", rdata, 8'h77);
        pop();
        check("pp_empty", empty, 1);

        // two-clock start glitch, then spike inside data bit 3
        rx = 1'b0; repeat (2) @(negedge clk);
        idle(24);
        check("glitch_empty", empty, 1);
        send_frame(9'h0B2, 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 0, 3);
        idle(6);
        check("spike_data", rdata, 8'hB2);
        check("spike_level", level, 1);
        pop();

        // 5-bit instance
        send_frame(9'h015, 5, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1, -1);
        idle(6);
        check("db5_data", rdata5, 5'h15);
        check("db5_level", level5, 1);
        check("db5_flags", {pe5, fe5, full5, ovr5, empty5}, 0);
        check("db5_main_empty", empty, 1);

        // Enable dropped during data bit 4
        fork
            send_frame(9'h096, 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 0, -1);
            begin repeat (44) @(negedge clk); en = 1'b0; end
        join
        idle(6);
        en = 1'b1;
        idle(4);
        check("en_empty", empty, 1);
        check("en_level", level, 0);
        send8(8'h69);
        check("en_after", rdata, 8'h69);
        pop();

        // reset mid-frame with three words queued
        send8(8'h11); send8(8'h22); send8(8'h33);
        check("rst_pre_level", level, 3);
        fork
            send_frame(9'h044, 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 0, -1);
            begin
                repeat (30) @(negedge clk);
                rstn = 1'b0;
                @(negedge clk);
                check_reset("midrst");
            end
        join
        idle(4);
        rstn = 1'b1;
        idle(10);
        check("rst_post_empty", empty, 1);
        send8(8'h5C);
        check("rst_post_data", rdata, 8'h5C);
        pop();

        // randomized frames against the word queue
        for (int f = 0; f < 40; f++) begin
            rd8   = 8'($urandom_range(0, 255));
            rpm   = 2'($urandom_range(0, 3));
            rtw   = 1'($urandom_range(0, 1));
            rflip = ($urandom_range(0, 3) == 0);
            rbad1 = ($urandom_range(0, 5) == 0);
            rbad2 = ($urandom_range(0, 5) == 0);
            div   = 16'(dvs[$urandom_range(0, 3)]);
            rgood = (rpm == 2'b10) ? ~(^rd8) : (^rd8);
            send_frame({1'b0, rd8}, 8, rpm, rgood ^ rflip, ~rbad1, ~rbad2, rtw, 0, -1);
            idle(6);
            q.push_back({rbad1 | (rtw & rbad2), (rpm == 2'b01 || rpm == 2'b10) & rflip, rd8});
            check("rnd_level", level, 5'(q.size()));
            if (q.size() >= 12 || $urandom_range(0, 3) == 0) drain();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
